// File: rtl/oc8051_port_wr_arb.sv
// -----------------------------------------------------------------------------
// oc8051_port_wr_arb
// Write arbiter in front of the port SFR block (P0-P3). The CPU write path has
// priority; a secondary master (debug / bit-bang unit) requests through a
// level req / pulsed ack handshake. A secondary request that has been pending
// for MAX_WAIT-1 cycles stalls the CPU for one cycle so it can get through.
// All port-block inputs come from one registered stage (1-cycle latency).
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   cpu_wr/_wr_bit/_addr/_data/_bit CPU write request fields
//   cpu_rmw                         CPU read-modify-write in progress
//   cpu_stall                       CPU must hold its write this cycle (comb)
//   ext_req/_wr_bit/_addr/_data/_bit secondary request (level) and fields
//   ext_ack, ext_err                completion pulse, error flag with it
//   wr, wr_bit, wr_addr, data_in,
//   bit_in, rmw                     registered outputs to the port block
// -----------------------------------------------------------------------------
module oc8051_port_wr_arb #(
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_wr,
    input  logic       cpu_wr_bit,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_data,
    input  logic       cpu_bit,
    input  logic       cpu_rmw,
    output logic       cpu_stall,
    input  logic       ext_req,
    input  logic       ext_wr_bit,
    input  logic [7:0] ext_addr,
    input  logic [7:0] ext_data,
    input  logic       ext_bit,
    output logic       ext_ack,
    output logic       ext_err,
    output logic       wr,
    output logic       wr_bit,
    output logic [7:0] wr_addr,
    output logic [7:0] data_in,
    output logic       bit_in,
    output logic       rmw
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] WAIT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] WAIT_ZERO = CNT_W'(0);

    // Only the four port SFRs and their bit addresses are accepted.
    function automatic logic port_addr_ok(input logic is_bit, input logic [7:0] addr);
        logic ok;
        ok = 1'b0;
        if (is_bit) begin
            case (addr[7:3])
                5'h10, 5'h12, 5'h14, 5'h16: ok = 1'b1;
                default:                    ok = 1'b0;
            endcase
        end else begin
            case (addr)
                8'h80, 8'h90, 8'hA0, 8'hB0: ok = 1'b1;
                default:                    ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             err_q, err_d;
    logic             h_wr_bit_q, h_wr_bit_d;
    logic [7:0]       h_addr_q, h_addr_d;
    logic [7:0]       h_data_q, h_data_d;
    logic             h_bit_q, h_bit_d;

    logic             wr_q, wr_d;
    logic             wr_bit_q, wr_bit_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       data_in_q, data_in_d;
    logic             bit_in_q, bit_in_d;
    logic             rmw_q;

    logic             issue_s;

    // cpu_rmw locks the port even after the wait budget has run out.
    assign issue_s   = (state_q == ST_PEND) && !cpu_rmw &&
                       (!cpu_wr || (wait_q == WAIT_LAST));
    assign cpu_stall = issue_s && cpu_wr;
    assign ext_ack   = (state_q == ST_ACK);
    assign ext_err   = (state_q == ST_ACK) && err_q;

    assign wr      = wr_q;
    assign wr_bit  = wr_bit_q;
    assign wr_addr = wr_addr_q;
    assign data_in = data_in_q;
    assign bit_in  = bit_in_q;
    assign rmw     = rmw_q;

    // Request FSM: capture, wait for a free slot, acknowledge.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        err_d      = err_q;
        h_wr_bit_d = h_wr_bit_q;
        h_addr_d   = h_addr_q;
        h_data_d   = h_data_q;
        h_bit_d    = h_bit_q;
        case (state_q)
            ST_IDLE: begin
                if (ext_req) begin
                    h_wr_bit_d = ext_wr_bit;
                    h_addr_d   = ext_addr;
                    h_data_d   = ext_data;
                    h_bit_d    = ext_bit;
                    if (port_addr_ok(ext_wr_bit, ext_addr)) begin
                        state_d = ST_PEND;
                    end else begin
                        state_d = ST_ACK;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (issue_s) begin
                    state_d = ST_ACK;
                end else if (wait_q != WAIT_LAST) begin
                    wait_d = wait_q + WAIT_ONE;
                end else begin
                    wait_d = wait_q;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                wait_d  = WAIT_ZERO;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = WAIT_ZERO;
                err_d   = 1'b0;
            end
        endcase
    end

    // Output stage source select: ext on issue, else CPU, else hold fields.
    always_comb begin
        wr_d      = 1'b0;
        wr_bit_d  = wr_bit_q;
        wr_addr_d = wr_addr_q;
        data_in_d = data_in_q;
        bit_in_d  = bit_in_q;
        if (issue_s) begin
            wr_d      = 1'b1;
            wr_bit_d  = h_wr_bit_q;
            wr_addr_d = h_addr_q;
            data_in_d = h_data_q;
            bit_in_d  = h_bit_q;
        end else if (cpu_wr) begin
            wr_d      = 1'b1;
            wr_bit_d  = cpu_wr_bit;
            wr_addr_d = cpu_addr;
            data_in_d = cpu_data;
            bit_in_d  = cpu_bit;
        end else begin
            wr_d      = 1'b0;
        end
    end

    // State, wait counter and ext holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_q     <= WAIT_ZERO;
            err_q      <= 1'b0;
            h_wr_bit_q <= 1'b0;
            h_addr_q   <= 8'h00;
            h_data_q   <= 8'h00;
            h_bit_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            h_wr_bit_q <= h_wr_bit_d;
            h_addr_q   <= h_addr_d;
            h_data_q   <= h_data_d;
            h_bit_q    <= h_bit_d;
        end
    end

    // Registered port-block interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            wr_bit_q  <= 1'b0;
            wr_addr_q <= 8'h00;
            data_in_q <= 8'h00;
            bit_in_q  <= 1'b0;
            rmw_q     <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            wr_bit_q  <= wr_bit_d;
            wr_addr_q <= wr_addr_d;
            data_in_q <= data_in_d;
            bit_in_q  <= bit_in_d;
            rmw_q     <= cpu_rmw;
        end
    end

endmodule
